// File: rtl/hog_svm_mc_if.sv
// Feature-stream input and scored-result output of the multi-class SVM stage.
// master drives features and o_ready; slave is the classifier.
interface hog_svm_mc_if #(
  parameter int FEA_W = 12,
  parameter int CLS_W = 2,
  parameter int SW_W  = 11
);
  logic             i_valid;
  logic             i_last;
  logic [FEA_W-1:0] fea;
  logic             o_valid;
  logic             o_ready;
  logic [CLS_W-1:0] o_class;
  logic [FEA_W-1:0] o_score;
  logic             o_detect;
  logic [SW_W-1:0]  sw_id;

  modport master (
    output i_valid, i_last, fea, o_ready,
    input  o_valid, o_class, o_score, o_detect, sw_id
  );

  modport slave (
    input  i_valid, i_last, fea, o_ready,
    output o_valid, o_class, o_score, o_detect, sw_id
  );
endinterface

// File: rtl/hog_svm_mc.sv
// Multi-class linear SVM: N_CLASS parallel dot products over one window of
// features, per-class bias, saturated score and arg-max into a one-deep result slot.
module hog_svm_mc #(
  parameter int FEA_I   = 4,
  parameter int FEA_F   = 8,
  parameter int N_FEA   = 36,
  parameter int N_CLASS = 4,
  parameter int ACC_G   = 8,
  parameter int SW_W    = 11,
  localparam int FEA_W  = FEA_I + FEA_F,
  localparam int COEF_W = FEA_W,
  localparam int ADDR_W = $clog2(N_FEA),
  localparam int CLS_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CLS_W-1:0]         cfg_cls,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [COEF_W-1:0]        cfg_data,
  input  logic                     bias_we,
  input  logic [CLS_W-1:0]         bias_cls,
  input  logic [COEF_W-1:0]        bias_data,
  input  logic [N_CLASS-1:0]       cls_en,
  hog_svm_mc_if.slave              strm,
  output logic                     o_overflow,
  output logic                     err_len,
  input  logic                     err_clr
);
  localparam int PROD_W = 2 * FEA_W;
  localparam int ACC_W  = 2 * FEA_W + ACC_G;
  localparam int SC_W   = ACC_W - FEA_F;
  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(N_FEA - 1);
  localparam logic signed [FEA_W-1:0] SC_MAX   = {1'b0, {(FEA_W-1){1'b1}}};
  localparam logic signed [FEA_W-1:0] SC_MIN   = {1'b1, {(FEA_W-1){1'b0}}};
  localparam logic signed [SC_W-1:0]  FULL_MAX = {{(SC_W-FEA_W){1'b0}}, SC_MAX};
  localparam logic signed [SC_W-1:0]  FULL_MIN = {{(SC_W-FEA_W){1'b1}}, SC_MIN};

  logic [N_CLASS*COEF_W-1:0] mem [N_FEA];
  logic [N_CLASS*COEF_W-1:0] ram_q;
  logic signed [COEF_W-1:0]  bias_r [N_CLASS];

  logic [ADDR_W-1:0]        idx;
  logic [SW_W-1:0]          wcnt;
  logic                     at_end, len_bad;
  logic                     s1_valid, s1_first, s1_last;
  logic signed [FEA_W-1:0]  s1_fea;
  logic [SW_W-1:0]          s1_sw;
  logic                     s2_valid, s2_first, s2_last;
  logic signed [PROD_W-1:0] prod [N_CLASS];
  logic [SW_W-1:0]          s2_sw;
  logic signed [ACC_W-1:0]  acc [N_CLASS];
  logic                     s3_done;
  logic [SW_W-1:0]          s3_sw;
  logic                     s4_valid;
  logic [CLS_W-1:0]         s4_class;
  logic signed [FEA_W-1:0]  s4_score;
  logic [SW_W-1:0]          s4_sw;
  logic                     slot_free;

  logic signed [ACC_W-1:0]  b_ext, sum;
  logic signed [SC_W-1:0]   full;
  logic signed [FEA_W-1:0]  sat_c, best_score;
  logic [CLS_W-1:0]         best_cls;
  logic                     found;

  assign at_end    = (idx == LAST_IDX);
  assign len_bad   = strm.i_valid && (strm.i_last != at_end);
  assign slot_free = !strm.o_valid || strm.o_ready;

  // Read-before-write: a write lands only for reads on later cycles.
  always_ff @(posedge clk) begin
    ram_q <= mem[idx];
    if (cfg_we && int'(cfg_addr) < N_FEA && int'(cfg_cls) < N_CLASS)
      mem[cfg_addr][int'(cfg_cls)*COEF_W +: COEF_W] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      wcnt     <= '0;
      err_len  <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_fea   <= '0;
      s1_sw    <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sw    <= '0;
      s3_done  <= 1'b0;
      s3_sw    <= '0;
      for (int unsigned c = 0; c < N_CLASS; c++) begin
        bias_r[c] <= '0;
        prod[c]   <= '0;
        acc[c]    <= '0;
      end
    end else begin
      if (bias_we && int'(bias_cls) < N_CLASS)
        bias_r[bias_cls] <= bias_data;

      // A malformed window just never raises last; the next first beat reloads acc.
      err_len  <= len_bad;
      s1_valid <= strm.i_valid;
      s1_first <= (idx == '0);
      s1_last  <= strm.i_valid && strm.i_last && at_end;
      s1_fea   <= strm.fea;
      s1_sw    <= wcnt;
      if (strm.i_valid) begin
        idx <= (len_bad || at_end) ? '0 : idx + ADDR_W'(1);
        if (!len_bad && at_end)
          wcnt <= wcnt + SW_W'(1);
      end

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sw    <= s1_sw;
      for (int unsigned c = 0; c < N_CLASS; c++)
        prod[c] <= s1_fea * $signed(ram_q[c*COEF_W +: COEF_W]);

      s3_done <= s2_valid && s2_last;
      s3_sw   <= s2_sw;
      for (int unsigned c = 0; c < N_CLASS; c++)
        if (s2_valid)
          acc[c] <= s2_first ? {{ACC_G{prod[c][PROD_W-1]}}, prod[c]}
                             : acc[c] + {{ACC_G{prod[c][PROD_W-1]}}, prod[c]};
    end
  end

  always_comb begin
    b_ext      = '0;
    sum        = '0;
    full       = '0;
    sat_c      = '0;
    best_score = SC_MIN;
    best_cls   = '0;
    found      = 1'b0;
    for (int unsigned c = 0; c < N_CLASS; c++) begin
      b_ext = {{(ACC_W-COEF_W){bias_r[c][COEF_W-1]}}, bias_r[c]};
      sum   = acc[c] + (b_ext <<< FEA_F);
      // Dropping the fraction bits of a two's complement value is a floor.
      full  = sum[ACC_W-1:FEA_F];
      if (full > FULL_MAX)      sat_c = SC_MAX;
      else if (full < FULL_MIN) sat_c = SC_MIN;
      else                      sat_c = full[FEA_W-1:0];
      if (cls_en[c] && (!found || sat_c > best_score)) begin
        best_score = sat_c;
        best_cls   = CLS_W'(c);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s4_valid      <= 1'b0;
      s4_class      <= '0;
      s4_score      <= '0;
      s4_sw         <= '0;
      strm.o_valid  <= 1'b0;
      strm.o_class  <= '0;
      strm.o_score  <= '0;
      strm.o_detect <= 1'b0;
      strm.sw_id    <= '0;
      o_overflow    <= 1'b0;
    end else begin
      s4_valid <= s3_done;
      if (s3_done) begin
        s4_class <= best_cls;
        s4_score <= best_score;
        s4_sw    <= s3_sw;
      end

      if (s4_valid && slot_free) begin
        strm.o_valid  <= 1'b1;
        strm.o_class  <= s4_class;
        strm.o_score  <= s4_score;
        strm.o_detect <= !s4_score[FEA_W-1] && (s4_score != '0);
        strm.sw_id    <= s4_sw;
      end else if (strm.o_valid && strm.o_ready) begin
        strm.o_valid <= 1'b0;
      end

      if (s4_valid && !slot_free) o_overflow <= 1'b1;
      else if (err_clr)           o_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hog_svm_mc.sv
// Bench for hog_svm_mc: directed window scenarios plus randomized windows scored
// by an integer-arithmetic reference model and a result queue.
module tb_hog_svm_mc;
  localparam int NF = 36;
  localparam int NC = 4;
  localparam int FW = 12;
  localparam int SW = 11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [1:0]      cfg_cls;
  logic [5:0]      cfg_addr;
  logic [FW-1:0]   cfg_data;
  logic            bias_we;
  logic [1:0]      bias_cls;
  logic [FW-1:0]   bias_data;
  logic [NC-1:0]   cls_en;
  logic            err_clr;
  logic            o_overflow;
  logic            err_len;

  always #5 clk = ~clk;

  hog_svm_mc_if #(.FEA_W(FW), .CLS_W(2), .SW_W(SW)) ifc ();

  hog_svm_mc #(
    .FEA_I(4), .FEA_F(8), .N_FEA(NF), .N_CLASS(NC), .ACC_G(8), .SW_W(SW)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .cfg_we     (cfg_we),
    .cfg_cls    (cfg_cls),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .bias_we    (bias_we),
    .bias_cls   (bias_cls),
    .bias_data  (bias_data),
    .cls_en     (cls_en),
    .strm       (ifc.slave),
    .o_overflow (o_overflow),
    .err_len    (err_len),
    .err_clr    (err_clr)
  );

  typedef struct {
    int cls;
    int score;
    int sw;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   tb_coef [NC][NF];
  int   tb_bias [NC];
  int   win [NF];
  int   tb_wcnt;
  exp_t expq [$];
  bit   mon_en;

  task automatic chk(input string tag, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int floor256(input longint s);
    longint q;
    q = s / 256;
    if ((s % 256) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  // Score = floor((sum(fea*coef) + bias*256) / 256), clamped to 12-bit signed;
  // highest enabled score wins, lowest class on ties, class 0 / -2048 if none enabled.
  function automatic exp_t predict();
    exp_t e;
    int   best;
    int   bc;
    bit   any;
    best = -2048;
    bc   = 0;
    any  = 1'b0;
    for (int c = 0; c < NC; c++) begin
      longint s;
      int     sc;
      s = longint'(tb_bias[c]) * 256;
      for (int i = 0; i < NF; i++) s += longint'(win[i]) * tb_coef[c][i];
      sc = floor256(s);
      if (sc > 2047)  sc = 2047;
      if (sc < -2048) sc = -2048;
      if (cls_en[c] && (!any || sc > best)) begin
        best = sc;
        bc   = c;
        any  = 1'b1;
      end
    end
    e.cls   = bc;
    e.score = best;
    e.sw    = tb_wcnt;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n && ifc.o_valid && ifc.o_ready) begin
      exp_t e;
      if (expq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("o_class", ifc.o_class, e.cls);
        chk("o_score", $signed(ifc.o_score), e.score);
        chk("o_detect", ifc.o_detect, (e.score > 0) ? 1 : 0);
        chk("sw_id", ifc.sw_id, e.sw);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int c, input int a, input int v);
    cfg_we   = 1'b1;
    cfg_cls  = 2'(c);
    cfg_addr = 6'(a);
    cfg_data = FW'(v);
    tick();
    cfg_we = 1'b0;
    tb_coef[c][a] = v;
  endtask

  task automatic set_class(input int c, input int v);
    for (int a = 0; a < NF; a++) wr_coef(c, a, v);
  endtask

  task automatic wr_bias(input int c, input int v);
    bias_we   = 1'b1;
    bias_cls  = 2'(c);
    bias_data = FW'(v);
    tick();
    bias_we = 1'b0;
    tb_bias[c] = v;
  endtask

  task automatic fill_win(input int v);
    for (int i = 0; i < NF; i++) win[i] = v;
  endtask

  task automatic send_window(input int nbeats, input int last_at, output int errs);
    bit legal;
    errs  = 0;
    legal = (nbeats == NF) && (last_at == NF - 1);
    for (int b = 0; b < nbeats; b++) begin
      ifc.i_valid = 1'b1;
      ifc.i_last  = (b == last_at);
      ifc.fea     = FW'(win[b]);
      tick();
      if (err_len) errs++;
    end
    ifc.i_valid = 1'b0;
    ifc.i_last  = 1'b0;
    if (legal) begin
      if (mon_en) expq.push_back(predict());
      tb_wcnt = (tb_wcnt + 1) % (1 << SW);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && expq.size() > 0; k++) tick();
    chk("drain", expq.size(), 0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ifc.i_valid = 1'b0;
    ifc.i_last  = 1'b0;
    ifc.fea     = '0;
    ifc.o_ready = 1'b1;
    cfg_we      = 1'b0;
    bias_we     = 1'b0;
    err_clr     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tb_wcnt = 0;
    for (int c = 0; c < NC; c++) tb_bias[c] = 0;
    expq.delete();
  endtask

  task automatic cfg_t1();
    for (int c = 0; c < NC; c++) set_class(c, (c == 1) ? 64 : 0);
    cls_en = 4'hF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int k;
    cfg_cls = '0; cfg_addr = '0; cfg_data = '0;
    bias_cls = '0; bias_data = '0; cls_en = 4'hF;
    mon_en = 1'b1;
    rst_n  = 1'b0;
    do_reset();

    // Reset state, sampled while reset is asserted
    rst_n = 1'b0;
    #2;
    chk("rst_o_valid", ifc.o_valid, 0);
    chk("rst_o_class", ifc.o_class, 0);
    chk("rst_o_score", ifc.o_score, 0);
    chk("rst_o_detect", ifc.o_detect, 0);
    chk("rst_sw_id", ifc.sw_id, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_err_len", err_len, 0);
    do_reset();

    // T1: single class active, latency of 4 edges after the i_last edge
    cfg_t1();
    fill_win(64);
    send_window(NF, NF - 1, errs);
    chk("t1_err", errs, 0);
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (ifc.o_valid) begin
        k = n;
        break;
      end
    end
    chk("t1_latency", k, 4);
    wait_drain();

    // T2: positive and negative saturation
    for (int c = 0; c < NC; c++) set_class(c, 256);
    fill_win(256);
    send_window(NF, NF - 1, errs);
    wait_drain();
    for (int c = 0; c < NC; c++) set_class(c, -256);
    send_window(NF, NF - 1, errs);
    wait_drain();

    // T3: tie and class enables
    set_class(0, 64); set_class(1, 32); set_class(2, 64); set_class(3, 0);
    fill_win(64);
    foreach (expq[i]) expq.delete(i);
    cls_en = 4'hF;    tick(); send_window(NF, NF - 1, errs); wait_drain();
    cls_en = 4'b1110; tick(); send_window(NF, NF - 1, errs); wait_drain();
    cls_en = 4'b0000; tick(); send_window(NF, NF - 1, errs); wait_drain();

    // T4: drops while the slot is held, then release and clear
    do_reset();
    cfg_t1();
    fill_win(64);
    mon_en = 1'b0;
    ifc.o_ready = 1'b0;
    for (int w = 0; w < 3; w++) send_window(NF, NF - 1, errs);
    repeat (8) tick();
    chk("t4_valid_held", ifc.o_valid, 1);
    chk("t4_sw_held", ifc.sw_id, 0);
    chk("t4_score_held", $signed(ifc.o_score), 576);
    chk("t4_overflow", o_overflow, 1);
    ifc.o_ready = 1'b1;
    tick();
    chk("t4_slot_freed", ifc.o_valid, 0);
    mon_en = 1'b1;
    send_window(NF, NF - 1, errs);
    wait_drain();
    chk("t4_overflow_sticky", o_overflow, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_overflow_clr", o_overflow, 0);

    // err_clr in the same cycle as a drop leaves the flag set
    mon_en = 1'b0;
    ifc.o_ready = 1'b0;
    send_window(NF, NF - 1, errs);
    send_window(NF, NF - 1, errs);
    repeat (3) tick();
    chk("t4b_no_drop_yet", o_overflow, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4b_clr_vs_drop", o_overflow, 1);
    ifc.o_ready = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;

    // T5: malformed windows
    do_reset();
    fill_win(64);
    send_window(21, 20, errs);
    chk("t5_early_last_err", errs, 1);
    tick();
    chk("t5_err_pulse_len", err_len, 0);
    repeat (6) tick();
    chk("t5_no_result", ifc.o_valid, 0);
    send_window(NF, -1, errs);
    chk("t5_missing_last_err", errs, 1);
    repeat (6) tick();
    chk("t5_no_result2", ifc.o_valid, 0);
    send_window(NF, NF - 1, errs);
    chk("t5_legal_err", errs, 0);
    wait_drain();

    // T6: asynchronous reset in the middle of a window
    do_reset();
    mon_en = 1'b0;
    ifc.o_ready = 1'b0;
    send_window(NF, NF - 1, errs);
    repeat (6) tick();
    chk("t6_held_before", ifc.o_valid, 1);
    send_window(10, -1, errs);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ifc.o_valid, 0);
    chk("t6_rst_class", ifc.o_class, 0);
    chk("t6_rst_score", ifc.o_score, 0);
    chk("t6_rst_detect", ifc.o_detect, 0);
    chk("t6_rst_sw", ifc.sw_id, 0);
    do_reset();
    mon_en = 1'b1;
    send_window(NF, NF - 1, errs);
    wait_drain();

    // Randomized configurations with back-to-back windows
    for (int w = 0; w < 10; w++) begin
      bit wide;
      int nb;
      wide = (w % 3 == 0);
      for (int c = 0; c < NC; c++) begin
        for (int a = 0; a < NF; a++)
          wr_coef(c, a, wide ? int'($urandom_range(0, 4095)) - 2048
                             : int'($urandom_range(0, 256)) - 128);
        wr_bias(c, int'($urandom_range(0, 4095)) - 2048);
      end
      cls_en = 4'($urandom_range(0, 15));
      tick();
      nb = $urandom_range(1, 3);
      for (int n = 0; n < nb; n++) begin
        for (int i = 0; i < NF; i++)
          win[i] = wide ? int'($urandom_range(0, 4095)) - 2048
                        : int'($urandom_range(0, 1024)) - 512;
        send_window(NF, NF - 1, errs);
        chk("rnd_err", errs, 0);
      end
      wait_drain();
    end

    chk("final_queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
